// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and PC generator state type
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HALT
    } pcg_state_e;
endpackage

// File: rtl/pc_gen_unit_if.sv
// rtl/pc_gen_unit_if.sv - instruction fetch request/grant bundle
interface pc_gen_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;

    modport master (output imem_req, output imem_addr, input  imem_gnt);
    modport slave  (input  imem_req, input  imem_addr, output imem_gnt);
endinterface

// File: rtl/pc_gen_unit_next_pc_calc.sv
// rtl/pc_gen_unit_next_pc_calc.sv - next fetch address select and alignment check
module next_pc_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_base,
    input  logic            pc_gen_out,
    input  logic            jalr_sel,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;

    assign pc_plus4      = pc + XLEN'(4);
    assign branch_target = pc + imm;
    // JALR drops bit 0 only; bit 1 can still leave the target misaligned.
    assign jalr_target   = (jalr_base + imm) & ~XLEN'(1);

    always_comb begin
        next_pc = pc_plus4;
        if (pc_gen_out) begin
            next_pc = jalr_sel ? jalr_target : branch_target;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);
endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - program counter, fetch handshake FSM, instret and fault tracking
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_gen_out,
    input  logic             jalr_sel,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  jalr_base,
    input  logic             stall,
    pc_gen_unit_if.master    imem,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instret,
    output logic             misalign_err
);
    import riscv_pkg::*;

    pcg_state_e      state;
    pcg_state_e      state_nxt;
    logic            fetch_req;
    logic            retire;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc         (pc),
        .imm        (imm),
        .jalr_base  (jalr_base),
        .pc_gen_out (pc_gen_out),
        .jalr_sel   (jalr_sel),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        retire    = 1'b0;
        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                fetch_req = 1'b1;
                // A stalled grant is dropped; memory re-delivers the same word.
                retire    = imem.imem_gnt & ~stall;
                if (retire && misaligned) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_VECTOR;
            instret      <= '0;
            misalign_err <= 1'b0;
        end else if (retire) begin
            instret <= instret + XLEN'(1);
            if (misaligned) begin
                misalign_err <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc;
    assign instr_valid    = retire;
endmodule
